// File: rtl/ahb_slave_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_port_arbiter
// Description : Per-slave-port round-robin arbiter for the AHB_Gen
//               interconnect. Drives one-hot address-phase (sel) and
//               data-phase (sel_data) channel selects for the payload muxes.
//               Grant is held across locked and SEQ/BUSY burst beats, and
//               every update is qualified by the slave's HREADY.
//               Optional macro AHB_ARB_BURST_LIMIT_EN forces re-arbitration
//               after MAX_BEATS beats of an unlocked burst when others wait.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_port_arbiter #(
  parameter int CHANNEL_NUM = 4,
  parameter int MAX_BEATS   = 16,
  parameter int ID_W        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [CHANNEL_NUM-1:0]      req,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0]      hmastlock,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [ID_W-1:0]             owner_id,
  output logic                        grant_valid
);

  localparam logic [1:0]      HTRANS_BUSY = 2'b01;
  localparam logic [1:0]      HTRANS_SEQ  = 2'b11;
  localparam logic [ID_W-1:0] PTR_RESET   = ID_W'(CHANNEL_NUM - 1);

  logic [CHANNEL_NUM-1:0] sel_q, sel_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic [ID_W-1:0]        owner_id_q, owner_id_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   grant_valid_q, grant_valid_d;

  logic                   owned;
  logic                   own_req;
  logic                   own_lock;
  logic [1:0]             own_trans;
  logic                   limit_hit;
  logic                   hold;
  logic                   win_found;
  logic [ID_W-1:0]        win_idx;
  logic [ID_W-1:0]        cand;

  // Current owner's view of the bus, indexed by the registered owner id.
  assign owned     = |sel_q;
  assign own_req   = req[owner_id_q];
  assign own_lock  = hmastlock[owner_id_q];
  assign own_trans = htrans[owner_id_q];

`ifdef AHB_ARB_BURST_LIMIT_EN
  localparam int              BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              other_req;
  logic              same_owner;

  // An unlocked owner that has used its beat budget yields to any waiter.
  assign other_req = |(req & ~sel_q);
  assign limit_hit = owned & (beat_q == BEAT_LAST) & ~own_lock & other_req;
  assign same_owner = hold | (owned & win_found & (win_idx == owner_id_q));

  // Beat counter: counts active beats of the same owner, saturating at the
  // limit, and restarts whenever ownership changes or the port goes idle.
  always_comb begin
    beat_d = beat_q;
    if (hready) begin
      if (!same_owner) begin
        beat_d = '0;
      end else if (own_trans[1] && (beat_q != BEAT_LAST)) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Beat counter register.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // Owner keeps the port through locked sequences and SEQ/BUSY beats.
  assign hold = owned & own_req &
                (own_lock | (own_trans == HTRANS_SEQ) | (own_trans == HTRANS_BUSY)) &
                ~limit_hit;

  // Round-robin scan starting just after the last winner, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= CHANNEL_NUM; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % CHANNEL_NUM);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state: everything freezes while hready is low.
  always_comb begin
    sel_d         = sel_q;
    sel_data_d    = sel_data_q;
    owner_id_d    = owner_id_q;
    ptr_d         = ptr_q;
    grant_valid_d = grant_valid_q;
    if (hready) begin
      // The beat just accepted enters its data phase under the current owner.
      sel_data_d = (owned && own_trans[1]) ? sel_q : '0;
      if (hold) begin
        grant_valid_d = 1'b1;
      end else if (win_found) begin
        sel_d          = '0;
        sel_d[win_idx] = 1'b1;
        owner_id_d     = win_idx;
        ptr_d          = win_idx;
        grant_valid_d  = 1'b1;
      end else begin
        sel_d         = '0;
        owner_id_d    = '0;
        grant_valid_d = 1'b0;
      end
    end
  end

  // Select and pointer registers.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      sel_q         <= '0;
      sel_data_q    <= '0;
      owner_id_q    <= '0;
      ptr_q         <= PTR_RESET;
      grant_valid_q <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      sel_data_q    <= sel_data_d;
      owner_id_q    <= owner_id_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign sel         = sel_q;
  assign sel_data    = sel_data_q;
  assign owner_id    = owner_id_q;
  assign grant_valid = grant_valid_q;

endmodule
`default_nettype wire
